// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a start bit, shifts one
// command byte out on device clock falls and checks the device ACK bit.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clka,
    input  logic       reset_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned FLT_W   = $clog2(FILTER_LEN + 1);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_PEN  = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_RELEASE   = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic             clk_filt_q, fall_q;
    logic [FLT_W-1:0] flt_cnt_q;

    state_t           state_q;
    logic [10:0]      frame_q;
    logic [3:0]       bit_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_q, busy_q, done_q, err_q, clk_oe_q, data_oe_q;
    logic [1:0]       code_q;

    // Two-flop synchronisers for both pad inputs; idle bus level is high.
    always_ff @(posedge clka or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk_in;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data_in;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Clock glitch filter: a new level is accepted after FILTER_LEN consecutive samples.
    always_ff @(posedge clka or negedge reset_n) begin
        if (!reset_n) begin
            clk_filt_q <= 1'b1;
            flt_cnt_q  <= '0;
            fall_q     <= 1'b0;
        end else begin
            fall_q <= 1'b0;
            if (clk_s2_q != clk_filt_q) begin
                if (flt_cnt_q == FLT_LAST) begin
                    clk_filt_q <= clk_s2_q;
                    flt_cnt_q  <= '0;
                    fall_q     <= ~clk_s2_q;
                end else begin
                    flt_cnt_q <= flt_cnt_q + FLT_W'(1);
                end
            end else begin
                flt_cnt_q <= '0;
            end
        end
    end

    // Transfer FSM with registered handshake, pulse and line-drive outputs.
    always_ff @(posedge clka or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'b00;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ready_q   <= 1'b1;
                    busy_q    <= 1'b0;
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    if (tx_valid && ready_q) begin
                        // frame[0] is the start bit, then data LSB first, parity, stop
                        frame_q  <= {1'b1, odd_parity(tx_data), tx_data, 1'b0};
                        cnt_q    <= '0;
                        bit_q    <= '0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        clk_oe_q <= 1'b1;
                        state_q  <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt_q == INH_LAST) begin
                        clk_oe_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= S_RELEASE;
                    end else begin
                        if (cnt_q == INH_PEN) begin
                            data_oe_q <= ~frame_q[0];
                        end
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RELEASE, S_SEND, S_ACK, S_WAIT_IDLE: begin
                    cnt_q <= fall_q ? '0 : cnt_q + CNT_W'(1);
                    if (!fall_q && (cnt_q == TO_LAST)) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        err_q     <= 1'b1;
                        code_q    <= 2'b10;
                        state_q   <= S_IDLE;
                    end else begin
                        case (state_q)
                            S_RELEASE: begin
                                if (fall_q) begin
                                    data_oe_q <= ~frame_q[1];
                                    bit_q     <= 4'd2;
                                    state_q   <= S_SEND;
                                end
                            end
                            S_SEND: begin
                                if (fall_q) begin
                                    data_oe_q <= ~frame_q[bit_q];
                                    bit_q     <= bit_q + 4'd1;
                                    if (bit_q == 4'd10) begin
                                        state_q <= S_ACK;
                                    end
                                end
                            end
                            S_ACK: begin
                                if (fall_q) begin
                                    if (dat_s2_q) begin
                                        clk_oe_q  <= 1'b0;
                                        data_oe_q <= 1'b0;
                                        err_q     <= 1'b1;
                                        code_q    <= 2'b01;
                                        state_q   <= S_IDLE;
                                    end else begin
                                        state_q <= S_WAIT_IDLE;
                                    end
                                end
                            end
                            S_WAIT_IDLE: begin
                                if (clk_filt_q && dat_s2_q) begin
                                    clk_oe_q  <= 1'b0;
                                    data_oe_q <= 1'b0;
                                    done_q    <= 1'b1;
                                    state_q   <= S_IDLE;
                                end
                            end
                            default: begin
                                state_q <= S_IDLE;
                            end
                        endcase
                    end
                end
                default: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready    = ready_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign err_code    = code_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: an open-drain PS/2 device model clocks frames out
// of the host, checks every bit on rising edges and the done/err outcome of each send.
module tb_ps2_host_tx;

    localparam int INH = 100;
    localparam int TO  = 3000;
    localparam int HP  = 40;

    logic       clka = 1'b0;
    logic       reset_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready, tx_busy, tx_done, tx_err;
    logic [1:0] err_code;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk, dev_data;

    int   n_vec   = 0;
    int   n_miss  = 0;
    int   n_pulse = 0;
    bit   chk_ready = 1'b0;
    logic exp_bits[$];
    int   exp_res[$];

    always #5 clka = ~clka;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (8)
    ) dut (
        .clka       (clka),
        .reset_n    (reset_n),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .err_code   (err_code),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outcome monitor: pops the expected result on every done/err pulse.
    always @(negedge clka) begin
        if (chk_ready) begin
            check("ready_after_pulse", {31'd0, tx_ready}, 32'd1);
            chk_ready = 1'b0;
        end
        if (reset_n && (tx_done || tx_err)) begin
            check("done_err_excl", {31'd0, tx_done & tx_err}, 32'd0);
            check("oe_at_pulse", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
            check("ready_in_pulse", {31'd0, tx_ready}, 32'd0);
            if (exp_res.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                check("result", tx_done ? 32'd0 : {30'd0, err_code}, exp_res.pop_front());
            end
            n_pulse++;
            chk_ready = 1'b1;
        end
    end

    task automatic wait_ready();
        int c = 0;
        while (!tx_ready && c < 2 * TO) begin
            @(negedge clka);
            c++;
        end
        check("ready_wait", {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] d, input int res);
        wait_ready();
        tx_valid = 1'b1;
        tx_data  = d;
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        exp_bits.push_back(~^d);
        exp_bits.push_back(1'b1);
        exp_res.push_back(res);
        @(negedge clka);
        tx_valid = 1'b0;
    endtask

    task automatic measure_inhibit();
        int   c = 0;
        logic dl = 1'b0;
        logic de = 1'b0;
        while (!ps2_clk_oe && c < 1000) begin
            @(negedge clka);
            c++;
        end
        check("inhibit_seen", {31'd0, ps2_clk_oe}, 32'd1);
        c = 0;
        while (ps2_clk_oe && c < 4 * INH) begin
            de = de | dl;
            dl = ps2_data_oe;
            c++;
            @(negedge clka);
        end
        check("inhibit_len", c, INH);
        check("start_on_last", {31'd0, dl}, 32'd1);
        check("start_early", {31'd0, de}, 32'd0);
        check("data_held_release", {31'd0, ps2_data_oe}, 32'd1);
    endtask

    task automatic dev_clocks(input logic ack, input logic glitch, input logic poke, input int stop_after);
        logic e;
        repeat (HP) @(negedge clka);
        check("start_bit", {31'd0, ps2_data_in}, 32'd0);
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            for (int j = 0; j < HP; j++) begin
                if (poke && k == 3) begin
                    tx_data  = 8'h55;
                    tx_valid = (j < 5);
                end
                if (glitch && k == 7) dev_clk = (j >= 10 && j < 13);
                @(negedge clka);
            end
            if (stop_after == k) return;
            if (k <= 10) begin
                if (exp_bits.size() == 0) begin
                    check("bit_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_bits.pop_front();
                    check($sformatf("bit%0d", k), {31'd0, ps2_data_in}, {31'd0, e});
                end
            end
            dev_clk = 1'b1;
            if (k == 11) dev_data = 1'b1;
            for (int j = 0; j < HP; j++) begin
                if (glitch && k == 4) dev_clk = !(j >= 10 && j < 13);
                if (ack && k == 10 && j == HP / 2) dev_data = 1'b0;
                @(negedge clka);
            end
        end
    endtask

    initial begin
        int c;
        int snap;
        bit any_oe;
        reset_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge clka);
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_pulses", {30'd0, tx_done, tx_err}, 32'd0);
        check("rst_code", {30'd0, err_code}, 32'd0);
        check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge clka);

        // 0xED with ACK; tx_valid poked while busy must be ignored
        send_byte(8'hED, 0);
        check("busy_in_transfer", {31'd0, tx_busy}, 32'd1);
        measure_inhibit();
        dev_clocks(1'b1, 1'b0, 1'b1, 0);
        wait_ready();
        check("code_after_done", {30'd0, err_code}, 32'd0);
        any_oe = 1'b0;
        repeat (30) begin
            @(negedge clka);
            any_oe = any_oe | ps2_clk_oe;
        end
        check("no_restart", {31'd0, any_oe}, 32'd0);

        send_byte(8'h07, 0);
        measure_inhibit();
        dev_clocks(1'b1, 1'b0, 1'b0, 0);
        send_byte(8'h00, 0);
        measure_inhibit();
        dev_clocks(1'b1, 1'b0, 1'b0, 0);

        // device holds data high on the 11th clock
        send_byte(8'hF0, 1);
        measure_inhibit();
        dev_clocks(1'b0, 1'b0, 1'b0, 0);
        wait_ready();
        repeat (50) @(negedge clka);
        check("code_held", {30'd0, err_code}, 32'd1);

        // device never clocks
        send_byte(8'hAA, 2);
        measure_inhibit();
        c = 0;
        while (!tx_err && c < 2 * TO) begin
            @(negedge clka);
            c++;
        end
        check("timeout_len", c, TO);
        exp_bits.delete();
        wait_ready();

        // clock glitches mid-frame
        send_byte(8'h3C, 0);
        measure_inhibit();
        dev_clocks(1'b1, 1'b1, 1'b0, 0);

        // reset after the 5th fall
        send_byte(8'h5A, 0);
        measure_inhibit();
        dev_clocks(1'b1, 1'b0, 1'b0, 5);
        snap = n_pulse;
        reset_n = 1'b0;
        #1;
        check("reset_mid_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("reset_mid_ready", {31'd0, tx_ready}, 32'd1);
        exp_bits.delete();
        exp_res.delete();
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (5) @(negedge clka);
        reset_n = 1'b1;
        repeat (50) @(negedge clka);
        check("reset_no_pulse", n_pulse, snap);

        send_byte(8'hFF, 0);
        measure_inhibit();
        dev_clocks(1'b1, 1'b0, 1'b0, 0);
        wait_ready();
        repeat (10) @(negedge clka);
        check("scoreboard_empty", exp_res.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
